lab085_seq_fsm: RTL
===================

# lab085_seq_fsm

Parametrised successor to the lab08 two-input sequencer FSM. It keeps the same four-state Moore sequence: idle, armed, hold, done. It adds three things: a programmable dwell time in the hold state, a visible cycle counter, and an optional arm-state timeout with a one-cycle flag. It is a standalone lab block driven by switch/button inputs X and T, and its state bits drive LEDs/7-seg.

## Interface
- HOLD_CYCLES, 4: cycles spent in HOLD (state 10) before DONE; legal range 1..2^CNT_W-1; value 1 reproduces the original one-cycle hold.
- TIMEOUT, 10: cycles allowed in ARM without T before abort (only with SEQ_TIMEOUT_EN); legal range 1..2^CNT_W-1.
- CNT_W, 4: width of the dwell/timeout counter.

Ports:
- clock  in  1  rising-edge system clock.
- reset_n  in  1  asynchronous, active-low reset.
- X  in  1  start qualifier; X==0 in IDLE arms the sequencer.
- T  in  1  trigger; T==1 in ARM starts the hold phase.
- Q1  out  1  state bit 1 (registered).
- Q0  out  1  state bit 0 (registered).
- cnt  out  CNT_W  cycles elapsed in current state (registered).
- tout  out  1  one-cycle timeout pulse (registered).

## Operation
- Encoding {Q1,Q0}: IDLE=00, ARM=01, HOLD=10, DONE=11.
- IDLE: X==0 -> ARM; X==1 -> stay.
- ARM: T==1 -> HOLD; T==0 -> stay, unless timeout fires (see Configuration).
- HOLD: cnt increments each cycle; when cnt==HOLD_CYCLES-1 -> DONE.
- DONE: unconditionally -> IDLE after one cycle; X and T are ignored.
- cnt is cleared to 0 on every state transition (the value seen in the first cycle of any state is 0).
- cnt holds 0 in IDLE and DONE.
- cnt never reaches or passes its wrap point under legal parameters. Behaviour with illegal parameters is undefined.
- T priority: in ARM, T==1 on the same edge as the timeout condition wins; the FSM goes to HOLD and tout stays 0.
- X and T are sampled only in the states listed. X in ARM/HOLD/DONE and T in IDLE/HOLD/DONE have no effect.
- Unreachable encodings do not exist (2 bits, 4 states). A default branch returns to IDLE anyway.

## Timing
- Reset (reset_n low, asynchronous): Q1=0, Q0=0, cnt=0, tout=0 immediately, regardless of clock.
- Reset mid-sequence aborts with no DONE and no tout. The first rising edge after reset_n rises evaluates IDLE normally.
- Latencies:
  - X low sampled in IDLE -> Q=01 on the following cycle (1-cycle latency).
  - T high sampled in ARM -> Q=10 next cycle.
  - Q=10 is held for exactly HOLD_CYCLES cycles, then Q=11 for exactly 1 cycle, then Q=00.
- Minimum IDLE-to-IDLE round trip: 3+HOLD_CYCLES cycles.
- All outputs change only on rising clock edges, except during asynchronous reset.

## Configuration
- SEQ_TIMEOUT_EN defined:
  - cnt counts in ARM.
  - If T==0 and cnt==TIMEOUT-1, the FSM returns to IDLE on that edge.
  - tout is 1 for exactly the first cycle of that IDLE, then 0.
  - ARM therefore lasts at most TIMEOUT cycles.
- SEQ_TIMEOUT_EN undefined:
  - ARM waits for T indefinitely with cnt held at 0.
  - tout is constant 0.
  - TIMEOUT is unused.

## Test plan
- Reset: assert reset_n=0 mid-HOLD between clock edges -> Q=00, cnt=0, tout=0 immediately; release, hold X=1 for 5 cycles -> Q stays 00.
- Nominal (HOLD_CYCLES=4): X=0 then T=1 -> Q sequence 00,01,10,10,10,10,11,00 with cnt 0,0,0,1,2,3,0,0.
- Legacy (HOLD_CYCLES=1): same stimulus -> Q sequence 00,01,10,11,00, matching the original sequencer.
- Wait in ARM (macro off): X=0, T=0 for 50 cycles -> Q stays 01, cnt=0, tout=0; then T=1 -> Q=10 next cycle.
- Timeout (macro on, TIMEOUT=10): X=0, T held 0 -> Q=01 for 10 cycles with cnt 0..9, then Q=00 with tout=1 for one cycle, then tout=0.
- Collision (macro on): T rises on the cycle cnt==9 in ARM -> Q=10 next cycle, tout stays 0.

Source files
------------

// File: rtl/lab085_seq_fsm.sv
// lab085_seq_fsm: idle/armed/hold/done Moore sequencer with programmable hold dwell and cycle counter.
// Optional ARM-state timeout with one-cycle tout pulse, enabled by defining SEQ_TIMEOUT_EN.
module lab085_seq_fsm #(
    parameter int HOLD_CYCLES = 4,
    parameter int TIMEOUT     = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             X,
    input  logic             T,
    output logic             Q1,
    output logic             Q0,
    output logic [CNT_W-1:0] cnt,
    output logic             tout
);
    typedef enum logic [1:0] {IDLE = 2'b00, ARM = 2'b01, HOLD = 2'b10, DONE = 2'b11} state_t;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tout;
    logic             w_last;
    // Shared terminal-count compare: HOLD dwell limit in HOLD, ARM timeout limit otherwise.
    assign w_last = r_cnt == (r_state == HOLD ? CNT_W'(HOLD_CYCLES - 1) : CNT_W'(TIMEOUT - 1));
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_tout  <= 1'b0;
        end else begin
            r_tout <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!X) r_state <= ARM;
                end
                ARM: begin
`ifdef SEQ_TIMEOUT_EN
                    if (T) begin
                        r_state <= HOLD;
                        r_cnt   <= '0;
                    end else if (w_last) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_tout  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`else
                    r_cnt <= '0;
                    if (T) r_state <= HOLD;
`endif
                end
                HOLD: begin
                    if (w_last) begin
                        r_state <= DONE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end
    assign Q1   = r_state[1];
    assign Q0   = r_state[0];
    assign cnt  = r_cnt;
    assign tout = r_tout;
endmodule
